// File: rtl/cycpuf_pkg.sv
// Shared types and constants for the cyclic RO PUF challenge-response harvester.
package cycpuf_pkg;

  localparam int CHAL_W_DEF    = 14;
  localparam int RESP_BITS_DEF = 32;

  // x^14 + x^13 + x^12 + x^2 + 1 : feedback taps on chal[13], chal[12], chal[11], chal[1]
  localparam logic [CHAL_W_DEF-1:0] LFSR_TAPS  = 14'b11100000000010;
  // All-zero is the LFSR lockup state, so a zero seed is swapped for this value
  localparam logic [CHAL_W_DEF-1:0] SEED_SUBST = 14'h0001;

  typedef enum logic [2:0] {
    IDLE,
    PRST,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  // Seed as actually used: never the lockup value
  function automatic logic [CHAL_W_DEF-1:0] nz_seed(input logic [CHAL_W_DEF-1:0] s);
    return (s == '0) ? SEED_SUBST : s;
  endfunction

endpackage

// File: rtl/cycpuf_chal_lfsr.sv
// Challenge register: loads a (zero-substituted) seed, steps as a 14-bit Fibonacci LFSR.
module cycpuf_chal_lfsr
  import cycpuf_pkg::*;
#(
  parameter int CHAL_W = CHAL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [CHAL_W-1:0] seed,
  output logic [CHAL_W-1:0] chal
);

  logic fb;

  assign fb = ^(chal & CHAL_W'(LFSR_TAPS));

  // Load has priority over step; the register holds otherwise
  always_ff @(posedge clk) begin
    if (!reset)     chal <= '0;
    else if (load)  chal <= CHAL_W'(nz_seed(CHAL_W_DEF'(seed)));
    else if (step)  chal <= {chal[CHAL_W-2:0], fb};
  end

endmodule

// File: rtl/cycpuf_crp_harvester.sv
// Harvests RESP_BITS PUF response bits from an LFSR-expanded seed challenge.
module cycpuf_crp_harvester
  import cycpuf_pkg::*;
#(
  parameter int CHAL_W        = CHAL_W_DEF,
  parameter int RESP_BITS     = RESP_BITS_DEF,
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [CHAL_W-1:0]    seed,
  output logic [CHAL_W-1:0]    puf_chal,
  output logic                 puf_enable,
  output logic                 puf_reset,
  input  logic                 puf_resp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CHAL_W-1:0]    out_seed,
  output logic [RESP_BITS-1:0] out_resp,
  output logic                 busy
);

  localparam int CNT_MAX = (SETTLE_CYCLES > RST_CYCLES) ? SETTLE_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(RESP_BITS + 1);

  state_t           state, nxt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             start_fire;
  logic             last_bit;

  assign start_fire = start_valid && (state == IDLE);
  assign last_bit   = (bit_cnt == BIT_W'(RESP_BITS - 1));

  // Next state and Moore outputs; outputs depend on state only
  always_comb begin
    nxt         = state;
    start_ready = 1'b0;
    busy        = 1'b1;
    puf_reset   = 1'b0;
    puf_enable  = 1'b0;
    out_valid   = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        puf_reset   = 1'b1;
        if (start_valid) nxt = PRST;
      end
      PRST: begin
        puf_reset = 1'b1;
        if (cyc_cnt == CNT_W'(RST_CYCLES - 1)) nxt = SETTLE;
      end
      SETTLE: begin
        puf_enable = 1'b1;
        if (cyc_cnt == CNT_W'(SETTLE_CYCLES - 1)) nxt = SAMPLE;
      end
      SAMPLE: begin
        puf_enable = 1'b1;
        nxt        = last_bit ? DONE : PRST;
      end
      DONE: begin
        puf_reset = 1'b1;
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // State register; the phase counter restarts on every state change
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cyc_cnt <= '0;
    end else begin
      state <= nxt;
      if (nxt != state)                            cyc_cnt <= '0;
      else if (state == PRST || state == SETTLE)   cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  // Bit counter, response shift register (first bit lands in MSB) and seed echo
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt  <= '0;
      out_resp <= '0;
      out_seed <= '0;
    end else if (start_fire) begin
      bit_cnt  <= '0;
      out_resp <= '0;
      out_seed <= CHAL_W'(nz_seed(CHAL_W_DEF'(seed)));
    end else if (state == SAMPLE) begin
      out_resp <= (out_resp << 1) | RESP_BITS'(puf_resp);
      if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  cycpuf_chal_lfsr #(
    .CHAL_W (CHAL_W)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (start_fire),
    .step  (state == SAMPLE),
    .seed  (seed),
    .chal  (puf_chal)
  );

endmodule

// File: tb/tb_cycpuf_crp_harvester.sv
// Directed bench for cycpuf_crp_harvester with a parity PUF stub (P = 2 + 4 + 1 = 7).
module tb_cycpuf_crp_harvester;

  localparam int CW = 14;
  localparam int RB = 4;
  localparam int RC = 2;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] seed = '0;
  logic          start_ready, puf_enable, puf_reset, puf_resp, out_valid, busy;
  logic [CW-1:0] puf_chal, out_seed;
  logic [RB-1:0] out_resp;

  int n_cmp = 0;
  int n_bad = 0;

  cycpuf_crp_harvester #(
    .CHAL_W        (CW),
    .RESP_BITS     (RB),
    .RST_CYCLES    (RC),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .seed        (seed),
    .puf_chal    (puf_chal),
    .puf_enable  (puf_enable),
    .puf_reset   (puf_reset),
    .puf_resp    (puf_resp),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_seed    (out_seed),
    .out_resp    (out_resp),
    .busy        (busy)
  );

  // PUF stub: parity of the challenge, only while oscillating
  assign puf_resp = puf_enable & (^puf_chal);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Idle outputs; full reset values only when coming out of reset
  task automatic check_idle(input string tag, input bit after_rst);
    chk({tag, ".start_ready"}, start_ready, 1);
    chk({tag, ".busy"},        busy, 0);
    chk({tag, ".puf_reset"},   puf_reset, 1);
    chk({tag, ".puf_enable"},  puf_enable, 0);
    chk({tag, ".out_valid"},   out_valid, 0);
    if (after_rst) begin
      chk({tag, ".out_resp"}, out_resp, 0);
      chk({tag, ".out_seed"}, out_seed, 0);
      chk({tag, ".puf_chal"}, puf_chal, 0);
    end
  endtask

  // Entered at a negedge with the DUT idle; leaves at the negedge after the out handshake
  task automatic run_req(input string tag, input logic [CW-1:0] sd,
                         input logic [RB-1:0] exp_resp, input logic [CW-1:0] exp_seed,
                         input int hold, input bit chk_chal,
                         input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                         input logic [CW-1:0] c2, input logic [CW-1:0] c3);
    logic [CW-1:0] chals[$];
    logic [CW-1:0] prev_chal;
    logic          prev_en;
    int rst_run, en_run, bad_chg, bad_sr, bad_hold, lat;
    rst_run = 0; en_run = 0; bad_chg = 0; bad_sr = 0; bad_hold = 0; lat = -1;
    prev_en = 1'b0; prev_chal = '0;

    chk({tag, ".start_ready"}, start_ready, 1);
    seed = sd;
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    seed = 14'h3fff;

    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 1) begin
        prev_chal = puf_chal;
        chals.push_back(puf_chal);
      end else if (puf_chal !== prev_chal) begin
        chals.push_back(puf_chal);
        if (!(prev_en && puf_reset)) bad_chg++;
        prev_chal = puf_chal;
      end
      if (puf_enable) en_run++;
      else if (en_run > 0) begin
        chk({tag, ".en_run"}, en_run, 5);
        en_run = 0;
      end
      if (out_valid) begin
        lat = i;
        break;
      end
      if (puf_reset) rst_run++;
      else if (rst_run > 0) begin
        chk({tag, ".rst_run"}, rst_run, 2);
        rst_run = 0;
      end
      if (start_ready || !busy) bad_sr++;
      prev_en = puf_enable;
      start_valid = (i % 3 == 0);
    end
    start_valid = 1'b0;

    chk({tag, ".latency"}, lat, 29);
    chk({tag, ".chal_chg_off_sample"}, bad_chg, 0);
    chk({tag, ".ready_while_busy"}, bad_sr, 0);
    chk({tag, ".n_chal"}, chals.size(), 5);
    if (chk_chal) begin
      chk({tag, ".chal0"}, chals[0], c0);
      chk({tag, ".chal1"}, chals[1], c1);
      chk({tag, ".chal2"}, chals[2], c2);
      chk({tag, ".chal3"}, chals[3], c3);
    end
    chk({tag, ".out_resp"}, out_resp, exp_resp);
    chk({tag, ".out_seed"}, out_seed, exp_seed);

    for (int j = 0; j < hold; j++) begin
      @(negedge clk);
      start_valid = (j % 2 == 1);
      if (out_valid !== 1'b1 || out_resp !== exp_resp || start_ready !== 1'b0) bad_hold++;
    end
    start_valid = 1'b0;
    if (hold > 0) chk({tag, ".hold_stable"}, bad_hold, 0);

    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_idle({tag, ".post"}, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("in_rst", 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_idle("rst_rel", 1'b1);

    run_req("nominal", 14'h0001, 4'b1100, 14'h0001, 0, 1'b1,
            14'h0001, 14'h0002, 14'h0005, 14'h000A);
    // back-to-back, zero seed, with back-pressure
    run_req("zero_seed", 14'h0000, 4'b1100, 14'h0001, 10, 1'b1,
            14'h0001, 14'h0002, 14'h0005, 14'h000A);
    run_req("s2000", 14'h2000, 4'b1110, 14'h2000, 0, 1'b1,
            14'h2000, 14'h0001, 14'h0002, 14'h0005);
    run_req("s3801", 14'h3801, 4'b0001, 14'h3801, 3, 1'b1,
            14'h3801, 14'h3003, 14'h2007, 14'h000E);

    // abort during SETTLE of bit 2 (cycles N+17..N+20)
    seed = 14'h2000;
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("abort.in_settle", puf_enable, 1);
    reset = 1'b0;
    @(negedge clk);
    check_idle("abort", 1'b1);
    reset = 1'b1;

    run_req("after_abort", 14'h0001, 4'b1100, 14'h0001, 0, 1'b0,
            14'h0, 14'h0, 14'h0, 14'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
